// File: rtl/kernel_pr_start_bcast_fifo_if.sv
// Handshake bundle between one start-token producer and NUM_CH broadcast consumers.
// master = producer/consumer side driving requests; slave = the FIFO itself.
interface kernel_pr_start_bcast_fifo_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_CH     = 2
);
  logic                         if_write_ce;
  logic                         if_write;
  logic [DATA_WIDTH-1:0]        if_din;
  logic                         if_full_n;
  logic                         if_almost_full;
  logic [ADDR_WIDTH:0]          if_count;
  logic [NUM_CH-1:0]            if_ch_en;
  logic [NUM_CH-1:0]            if_read_ce;
  logic [NUM_CH-1:0]            if_read;
  logic [NUM_CH-1:0]            if_empty_n;
  logic [NUM_CH*DATA_WIDTH-1:0] if_dout;

  modport master (
    output if_write_ce, if_write, if_din, if_ch_en, if_read_ce, if_read,
    input  if_full_n, if_almost_full, if_count, if_empty_n, if_dout
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_ch_en, if_read_ce, if_read,
    output if_full_n, if_almost_full, if_count, if_empty_n, if_dout
  );
endinterface

// File: rtl/kernel_pr_start_bcast_fifo.sv
// Broadcast start-token FIFO: every word reaches each enabled channel (FWFT); a slot frees once the slowest enabled channel read it.
// Flags/count registered from next-state pointers (write->valid and read->not-full in one cycle); full drops writes, empty ignores reads.
module kernel_pr_start_bcast_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int AFULL_THR  = 3
) (
  input logic                         clk,
  input logic                         reset,
  kernel_pr_start_bcast_fifo_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0] THR_V   = PW'(AFULL_THR);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         wptr_nxt;
  logic [PW-1:0]         rptr     [NUM_CH];
  logic [PW-1:0]         rptr_nxt [NUM_CH];
  logic [PW-1:0]         diff;
  logic [PW-1:0]         occ_nxt;
  logic [PW-1:0]         count_q;
  logic [NUM_CH-1:0]     empty_n_q;
  logic [NUM_CH-1:0]     empty_n_nxt;
  logic [NUM_CH-1:0]     rd_acc;
  logic                  full_n_q;
  logic                  afull_q;
  logic                  wr_acc;

  // Acceptance uses the registered flags only, so a full FIFO refuses a write even if a read frees a slot this cycle.
  assign wr_acc   = bus.if_write & bus.if_write_ce & full_n_q;
  assign rd_acc   = bus.if_read & bus.if_read_ce & empty_n_q & bus.if_ch_en;
  assign wptr_nxt = wptr + PW'(wr_acc);

  always_comb begin
    rptr_nxt    = '{default: '0};
    empty_n_nxt = '0;
    occ_nxt     = '0;
    diff        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // A disabled channel shadows the write pointer so it never holds back occupancy.
      rptr_nxt[c]    = bus.if_ch_en[c] ? (rptr[c] + PW'(rd_acc[c])) : wptr_nxt;
      empty_n_nxt[c] = (rptr_nxt[c] != wptr_nxt) & bus.if_ch_en[c];
      diff           = wptr_nxt - rptr_nxt[c];
      if (bus.if_ch_en[c] && (diff > occ_nxt)) begin
        occ_nxt = diff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        rptr[c] <= '0;
      end
      empty_n_q <= '0;
      full_n_q  <= 1'b1;
      afull_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      wptr      <= wptr_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        rptr[c] <= rptr_nxt[c];
      end
      empty_n_q <= empty_n_nxt;
      full_n_q  <= (occ_nxt != DEPTH_V);
      afull_q   <= (occ_nxt >= THR_V);
      count_q   <= occ_nxt;
    end
  end

  // Storage ring is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= bus.if_din;
    end
  end

  always_comb begin
    bus.if_dout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.if_dout[c*DATA_WIDTH +: DATA_WIDTH] = mem[rptr[c][ADDR_WIDTH-1:0]];
    end
  end

  assign bus.if_full_n      = full_n_q;
  assign bus.if_almost_full = afull_q;
  assign bus.if_count       = count_q;
  assign bus.if_empty_n     = empty_n_q;
endmodule

// File: tb/tb_kernel_pr_start_bcast_fifo.sv
// Bench for the broadcast start FIFO: directed scenarios plus random traffic against a word-count reference model.
module tb_kernel_pr_start_bcast_fifo;
  localparam int DW = 8, AW = 2, DEPTH = 4, NCH = 2, THR = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kernel_pr_start_bcast_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) bus ();

  kernel_pr_start_bcast_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_CH(NCH), .AFULL_THR(THR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: absolute counts of words written and read per channel since reset.
  logic [DW-1:0]  words [4096];
  int             wcnt;
  int             rcnt [NCH];
  logic [NCH-1:0] m_en;

  function automatic int exp_count();
    int m = 0;
    for (int c = 0; c < NCH; c++)
      if (m_en[c] && (wcnt - rcnt[c]) > m) m = wcnt - rcnt[c];
    return m;
  endfunction

  function automatic logic [NCH-1:0] exp_empty_n();
    logic [NCH-1:0] e = '0;
    for (int c = 0; c < NCH; c++) e[c] = m_en[c] && (rcnt[c] < wcnt);
    return e;
  endfunction

  function automatic logic [DW-1:0] exp_dout(int c);
    return words[rcnt[c]];
  endfunction

  function automatic logic [DW-1:0] dout_of(int c);
    return bus.if_dout[c*DW +: DW];
  endfunction

  task automatic model_reset();
    wcnt = 0;
    for (int c = 0; c < NCH; c++) rcnt[c] = 0;
    m_en = '0;
  endtask

  task automatic set_idle();
    bus.if_write    = 1'b0;
    bus.if_write_ce = 1'b1;
    bus.if_din      = '0;
    bus.if_read     = '0;
    bus.if_read_ce  = '1;
  endtask

  // Advance one clock, updating the model from the currently driven inputs.
  task automatic step();
    logic           wacc;
    logic [NCH-1:0] en_now;
    logic [NCH-1:0] racc;
    en_now = exp_empty_n();
    wacc   = bus.if_write & bus.if_write_ce & (exp_count() != DEPTH);
    for (int c = 0; c < NCH; c++)
      racc[c] = bus.if_read[c] & bus.if_read_ce[c] & bus.if_ch_en[c] & en_now[c];
    if (wacc) begin
      words[wcnt] = bus.if_din;
      wcnt++;
    end
    for (int c = 0; c < NCH; c++) begin
      if (!bus.if_ch_en[c]) rcnt[c] = wcnt;
      else if (racc[c]) rcnt[c]++;
    end
    m_en = bus.if_ch_en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    bus.if_ch_en = '1;
    bus.if_write = 1'b1;
    bus.if_din   = 8'hAA;
    bus.if_read  = '1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.if_full_n !== 1'b1) begin n_errors++; $display("FAIL rst_full_n: got %0b exp 1", bus.if_full_n); end
    n_checks++; if (bus.if_empty_n !== 2'b00) begin n_errors++; $display("FAIL rst_empty_n: got %0b exp 00", bus.if_empty_n); end
    n_checks++; if (bus.if_count !== 3'd0) begin n_errors++; $display("FAIL rst_count: got %0d exp 0", bus.if_count); end
    n_checks++; if (bus.if_almost_full !== 1'b0) begin n_errors++; $display("FAIL rst_afull: got %0b exp 0", bus.if_almost_full); end
    set_idle();
    model_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (bus.if_full_n !== 1'b1) begin n_errors++; $display("FAIL rel_full_n: got %0b exp 1", bus.if_full_n); end
    n_checks++; if (bus.if_empty_n !== 2'b00) begin n_errors++; $display("FAIL rel_empty_n: got %0b exp 00", bus.if_empty_n); end
    n_checks++; if (bus.if_count !== 3'd0) begin n_errors++; $display("FAIL rel_count: got %0d exp 0", bus.if_count); end
  endtask

  task automatic test_broadcast();
    logic [DW-1:0] vals [3];
    vals[0] = 8'h41; vals[1] = 8'h42; vals[2] = 8'h43;
    set_idle();
    bus.if_ch_en = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.if_write = 1'b1;
      bus.if_din   = vals[i];
      step();
    end
    set_idle();
    step();
    n_checks++; if (bus.if_empty_n !== 2'b11) begin n_errors++; $display("FAIL bc_empty_n: got %0b exp 11", bus.if_empty_n); end
    for (int c = 0; c < NCH; c++) begin
      n_checks++; if (dout_of(c) !== vals[0]) begin n_errors++; $display("FAIL bc_head ch%0d: got %0h exp %0h", c, dout_of(c), vals[0]); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dout_of(0) !== vals[i]) begin n_errors++; $display("FAIL bc_ch0_data%0d: got %0h exp %0h", i, dout_of(0), vals[i]); end
      bus.if_read = 2'b01;
      step();
    end
    set_idle();
    n_checks++; if (bus.if_count !== 3'd3) begin n_errors++; $display("FAIL bc_count_slow: got %0d exp 3", bus.if_count); end
    n_checks++; if (bus.if_empty_n !== 2'b10) begin n_errors++; $display("FAIL bc_empty_mid: got %0b exp 10", bus.if_empty_n); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dout_of(1) !== vals[i]) begin n_errors++; $display("FAIL bc_ch1_data%0d: got %0h exp %0h", i, dout_of(1), vals[i]); end
      bus.if_read = 2'b10;
      step();
    end
    set_idle();
    n_checks++; if (bus.if_count !== 3'd0) begin n_errors++; $display("FAIL bc_count_end: got %0d exp 0", bus.if_count); end
    n_checks++; if (bus.if_empty_n !== 2'b00) begin n_errors++; $display("FAIL bc_empty_end: got %0b exp 00", bus.if_empty_n); end
  endtask

  task automatic test_full();
    set_idle();
    bus.if_ch_en = 2'b11;
    for (int i = 0; i < 4; i++) begin
      bus.if_write = 1'b1;
      bus.if_din   = 8'h10 + 8'(i);
      step();
      n_checks++; if (bus.if_almost_full !== (i + 1 >= THR)) begin n_errors++; $display("FAIL full_afull%0d: got %0b exp %0b", i, bus.if_almost_full, (i + 1 >= THR)); end
      n_checks++; if (bus.if_full_n !== (i != 3)) begin n_errors++; $display("FAIL full_full_n%0d: got %0b exp %0b", i, bus.if_full_n, (i != 3)); end
    end
    bus.if_din = 8'hEE;
    step();
    set_idle();
    n_checks++; if (bus.if_count !== 3'd4) begin n_errors++; $display("FAIL full_drop_count: got %0d exp 4", bus.if_count); end
    bus.if_read = 2'b01;
    step();
    set_idle();
    n_checks++; if (bus.if_full_n !== 1'b0) begin n_errors++; $display("FAIL full_slow_gate: got %0b exp 0", bus.if_full_n); end
    bus.if_read = 2'b10;
    step();
    set_idle();
    n_checks++; if (bus.if_full_n !== 1'b1) begin n_errors++; $display("FAIL full_release: got %0b exp 1", bus.if_full_n); end
    n_checks++; if (bus.if_count !== 3'd3) begin n_errors++; $display("FAIL full_release_count: got %0d exp 3", bus.if_count); end
    for (int i = 1; i < 4; i++) begin
      for (int c = 0; c < NCH; c++) begin
        n_checks++; if (dout_of(c) !== 8'h10 + 8'(i)) begin n_errors++; $display("FAIL full_drain ch%0d w%0d: got %0h exp %0h", c, i, dout_of(c), 8'h10 + 8'(i)); end
      end
      bus.if_read = 2'b11;
      step();
    end
    set_idle();
    n_checks++; if (bus.if_empty_n !== 2'b00) begin n_errors++; $display("FAIL full_dropped_word: got %0b exp 00", bus.if_empty_n); end
  endtask

  task automatic test_simultaneous();
    set_idle();
    bus.if_ch_en = 2'b11;
    bus.if_write = 1'b1;
    bus.if_din = 8'h58; step();
    bus.if_din = 8'h59; step();
    set_idle();
    step();
    bus.if_write = 1'b1;
    bus.if_din   = 8'h44;
    bus.if_read  = 2'b11;
    step();
    set_idle();
    n_checks++; if (bus.if_count !== 3'd2) begin n_errors++; $display("FAIL sim_count: got %0d exp 2", bus.if_count); end
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCH; c++) begin
        n_checks++; if (dout_of(c) !== (i == 0 ? 8'h59 : 8'h44)) begin n_errors++; $display("FAIL sim_order ch%0d i%0d: got %0h", c, i, dout_of(c)); end
      end
      bus.if_read = 2'b11;
      step();
    end
    set_idle();
    n_checks++; if (bus.if_count !== 3'd0) begin n_errors++; $display("FAIL sim_count_end: got %0d exp 0", bus.if_count); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent [$];
    logic [DW-1:0] got0 [$];
    logic [DW-1:0] got1 [$];
    int bad = 0;
    set_idle();
    bus.if_ch_en = 2'b11;
    for (int i = 0; i < 23; i++) begin
      if (bus.if_empty_n[0]) got0.push_back(dout_of(0));
      if (bus.if_empty_n[1]) got1.push_back(dout_of(1));
      bus.if_read  = 2'b11;
      bus.if_write = (i < 20);
      bus.if_din   = 8'($urandom);
      if (i < 20) sent.push_back(bus.if_din);
      step();
      if (bus.if_count > 3'd1 || bus.if_count !== 3'(exp_count())) bad++;
    end
    set_idle();
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL wrap_count: %0d bad cycles, exp 0", bad); end
    n_checks++; if (got0 != sent) begin n_errors++; $display("FAIL wrap_ch0_stream: got %0d words, exp %0d in order", got0.size(), sent.size()); end
    n_checks++; if (got1 != sent) begin n_errors++; $display("FAIL wrap_ch1_stream: got %0d words, exp %0d in order", got1.size(), sent.size()); end
  endtask

  task automatic test_disable();
    set_idle();
    bus.if_ch_en = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.if_write = 1'b1;
      bus.if_din   = 8'h20 + 8'(i);
      step();
    end
    set_idle();
    n_checks++; if (bus.if_full_n !== 1'b0) begin n_errors++; $display("FAIL dis_full_n: got %0b exp 0", bus.if_full_n); end
    n_checks++; if (bus.if_empty_n !== 2'b01) begin n_errors++; $display("FAIL dis_empty_n: got %0b exp 01", bus.if_empty_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (dout_of(0) !== 8'h20 + 8'(i)) begin n_errors++; $display("FAIL dis_ch0_data%0d: got %0h exp %0h", i, dout_of(0), 8'h20 + 8'(i)); end
      bus.if_read = 2'b11;
      step();
    end
    set_idle();
    n_checks++; if (bus.if_count !== 3'd0) begin n_errors++; $display("FAIL dis_count: got %0d exp 0", bus.if_count); end
    bus.if_ch_en = 2'b11;
    step();
    n_checks++; if (bus.if_empty_n !== 2'b00) begin n_errors++; $display("FAIL dis_reen_empty: got %0b exp 00", bus.if_empty_n); end
    bus.if_write = 1'b1;
    bus.if_din   = 8'h45;
    step();
    set_idle();
    n_checks++; if (bus.if_empty_n !== 2'b11) begin n_errors++; $display("FAIL dis_e_vld: got %0b exp 11", bus.if_empty_n); end
    for (int c = 0; c < NCH; c++) begin
      n_checks++; if (dout_of(c) !== 8'h45) begin n_errors++; $display("FAIL dis_e_data ch%0d: got %0h exp 45", c, dout_of(c)); end
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] ee;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1'b0;
        #1;
        n_checks++; if (bus.if_count !== 3'd0 || bus.if_empty_n !== 2'b00) begin n_errors++; $display("FAIL rnd_async_rst: count %0d empty_n %0b exp 0/00", bus.if_count, bus.if_empty_n); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
      end
      bus.if_write    = 1'($urandom_range(0, 2) != 0);
      bus.if_write_ce = 1'($urandom_range(0, 5) != 0);
      bus.if_din      = 8'($urandom);
      bus.if_read     = 2'($urandom);
      bus.if_read_ce  = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) bus.if_ch_en = 2'($urandom);
      step();
      ee = exp_empty_n();
      n_checks++; if (bus.if_count !== 3'(exp_count())) begin n_errors++; $display("FAIL rnd_count c%0d: got %0d exp %0d", i, bus.if_count, exp_count()); end
      n_checks++; if (bus.if_full_n !== (exp_count() != DEPTH)) begin n_errors++; $display("FAIL rnd_full_n c%0d: got %0b", i, bus.if_full_n); end
      n_checks++; if (bus.if_almost_full !== (exp_count() >= THR)) begin n_errors++; $display("FAIL rnd_afull c%0d: got %0b", i, bus.if_almost_full); end
      n_checks++; if (bus.if_empty_n !== ee) begin n_errors++; $display("FAIL rnd_empty_n c%0d: got %0b exp %0b", i, bus.if_empty_n, ee); end
      for (int c = 0; c < NCH; c++) begin
        if (ee[c]) begin
          n_checks++; if (dout_of(c) !== exp_dout(c)) begin n_errors++; $display("FAIL rnd_dout c%0d ch%0d: got %0h exp %0h", i, c, dout_of(c), exp_dout(c)); end
        end
      end
    end
    set_idle();
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    bus.if_ch_en = '1;
    model_reset();
    test_reset();
    test_broadcast();
    test_full();
    test_simultaneous();
    test_wrap();
    test_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
